// File: rtl/rc_input_buffer.sv
// First-word-fall-through flit FIFO feeding one RC port; pops only on rc_ready.
// Optional sticky overflow flag enabled by defining RC_IB_OVERFLOW_CHK_EN.
module rc_input_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned DATASIZE  = 30,
    parameter int unsigned router_ID = 6
) (
    input  logic                rc_clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] data_in,
    input  logic                valid_in,
    output logic                ready_out,
    output logic [DATASIZE-1:0] data_out,
    output logic                valid_out,
    input  logic                rc_ready,
    output logic [WIDTH:0]      count
`ifdef RC_IB_OVERFLOW_CHK_EN
    ,
    output logic                overflow
`endif
);

    localparam logic [WIDTH:0] FullCnt = (WIDTH + 1)'(DEPTH);

    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH:0]      count_q, count_d;
    logic                full, empty, push, pop;

    // Instance-uniformity parameter only.
    logic [7:0] unused_router_id;
    assign unused_router_id = 8'(router_ID);

    always_comb begin
        full      = (count_q == FullCnt);
        empty     = (count_q == '0);
        ready_out = !full;
        valid_out = !empty;
        push      = valid_in && ready_out;
        pop       = valid_out && rc_ready;
        data_out  = empty ? '0 : mem_q[rd_ptr_q];
        count     = count_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + WIDTH'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; empty masking hides stale entries.
    always_ff @(posedge rc_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef RC_IB_OVERFLOW_CHK_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q || (valid_in && full);
        overflow   = overflow_q;
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end
`endif

endmodule

// File: tb/tb_rc_input_buffer.sv
// Scoreboard bench for rc_input_buffer: directed test-plan scenarios plus random traffic.
module tb_rc_input_buffer;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned WIDTH    = 2;
    localparam int unsigned DATASIZE = 30;

    logic                rc_clk = 1'b0;
    logic                rst_n;
    logic [DATASIZE-1:0] data_in;
    logic                valid_in;
    logic                ready_out;
    logic [DATASIZE-1:0] data_out;
    logic                valid_out;
    logic                rc_ready;
    logic [WIDTH:0]      count;
`ifdef RC_IB_OVERFLOW_CHK_EN
    logic                overflow;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: accepted flits in order, plus occupancy.
    logic [DATASIZE-1:0] exp_q[$];
    int                  mdl_cnt = 0;
    bit                  mdl_ovf = 1'b0;

    rc_input_buffer #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .DATASIZE (DATASIZE),
        .router_ID(6)
    ) dut (
        .rc_clk   (rc_clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .data_out (data_out),
        .valid_out(valid_out),
        .rc_ready (rc_ready),
        .count    (count)
`ifdef RC_IB_OVERFLOW_CHK_EN
        ,
        .overflow (overflow)
`endif
    );

    always #5 rc_clk = ~rc_clk;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Model update on each edge, using pre-edge occupancy.
    always @(posedge rc_clk) begin
        if (rst_n) begin
            bit do_push, do_pop;
            do_push = valid_in && (mdl_cnt < DEPTH);
            do_pop  = rc_ready && (mdl_cnt > 0);
            if (valid_in && mdl_cnt == DEPTH) mdl_ovf = 1'b1;
            if (do_push) exp_q.push_back(data_in);
            mdl_cnt = mdl_cnt + int'(do_push) - int'(do_pop);
        end
    end

    // Monitor: compare presented state mid-cycle; retire the head when it is consumed.
    always @(negedge rc_clk) begin
        check("count", longint'(count), longint'(mdl_cnt));
        check("ready_out", longint'(ready_out), longint'(mdl_cnt != DEPTH));
        check("valid_out", longint'(valid_out), longint'(mdl_cnt != 0));
`ifdef RC_IB_OVERFLOW_CHK_EN
        check("overflow", longint'(overflow), longint'(mdl_ovf));
`endif
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_flit", longint'(data_out), 0);
            end else if (rc_ready) begin
                check("data_out_pop", longint'(data_out), longint'(exp_q.pop_front()));
            end else begin
                check("data_out_head", longint'(data_out), longint'(exp_q[0]));
            end
        end else begin
            check("data_out_empty", longint'(data_out), 0);
        end
    end

    task automatic drive(input bit v, input logic [DATASIZE-1:0] d, input bit r);
        valid_in = v;
        data_in  = d;
        rc_ready = r;
        @(posedge rc_clk);
        #1;
    endtask

    task automatic fill(input logic [DATASIZE-1:0] base);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, base + DATASIZE'(i), 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, '0, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        rc_ready = 1'b0;
        repeat (2) @(posedge rc_clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0);

        // Reset mid-fill: asynchronous clear between edges.
        drive(1'b1, 30'h0000_0011, 1'b0);
        drive(1'b1, 30'h0000_0022, 1'b0);
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        #1;
        check("rst_count", longint'(count), 0);
        check("rst_valid_out", longint'(valid_out), 0);
        check("rst_data_out", longint'(data_out), 0);
        check("rst_ready_out", longint'(ready_out), 1);
`ifdef RC_IB_OVERFLOW_CHK_EN
        check("rst_overflow", longint'(overflow), 0);
`endif
        @(posedge rc_clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 30'h0000_0AA, 1'b0);
        check("first_after_reset", longint'(data_out), 30'h0000_0AA);
        drive(1'b0, '0, 1'b1);

        // Fill to full, then an overflow attempt that must be dropped.
        fill(30'h01);
        drive(1'b1, 30'h05, 1'b0);
        drive(1'b1, 30'h05, 1'b0);
        check("full_count_hold", longint'(count), 4);

        // Drain across the read-pointer wrap, then reuse the wrapped slot.
        drain();
        drive(1'b1, 30'h06, 1'b0);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);

        // Streaming: concurrent push and pop hold occupancy at one.
        for (int i = 0; i < 10; i++) drive(1'b1, 30'h10 + DATASIZE'(i), 1'b1);
        drain();

        // Full with simultaneous pop: push refused this cycle, accepted next.
        fill(30'h30);
        drive(1'b1, 30'h20, 1'b1);
        check("full_pop_count", longint'(count), 3);
        drive(1'b1, 30'h20, 1'b0);
        check("refill_count", longint'(count), 4);
        drain();

        // Spurious rc_ready while empty.
        repeat (3) drive(1'b0, '0, 1'b1);
        check("spurious_count", longint'(count), 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'b1 & ($urandom_range(0, 3) != 0), DATASIZE'($urandom),
                  1'b1 & ($urandom_range(0, 2) != 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
